// File: rtl/dual_cam_burst_arbiter_pkg.sv
// Shared definitions for the dual camera burst arbiter: FSM encoding and
// burst header layout.
package dual_cam_burst_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] HDR_MAGIC     = 4'hA;
  localparam int         HDR_W         = 16;
  localparam int         HDR_MAGIC_LSB = 12;
  localparam int         HDR_CH_BIT    = 8;
  localparam int         HDR_SEQ_LSB   = 0;

  function automatic logic [HDR_W-1:0] make_header(input logic ch, input logic [7:0] seq);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 4] = HDR_MAGIC;
    h[HDR_CH_BIT]         = ch;
    h[HDR_SEQ_LSB +: 8]   = seq;
    return h;
  endfunction

endpackage

// File: rtl/dual_cam_burst_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the requester not served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_ch
);

  logic last_ch;

  always_comb begin
    gnt_valid = |req;
    gnt_ch    = req[1];
    if (&req) gnt_ch = ~last_ch;
  end

  // Reset to channel 1 so channel 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  last_ch <= 1'b1;
    else if (take && gnt_valid)  last_ch <= gnt_ch;
  end

endmodule

// File: rtl/dual_cam_burst_arbiter.sv
// Reads fixed-length bursts from two camera FIFOs and emits them as
// header + data packets, arbitrating round-robin between the cameras.
//
// state    | meaning
// ST_IDLE  | waiting for en, tx_ready and an eligible channel
// ST_READ  | rdreq high on granted channel, header then data beats out
// ST_DRAIN | last FIFO word in flight, eop beat driven
module dual_cam_burst_arbiter
  import dual_cam_burst_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              tx_ready,
  input  logic [ADDR_W-1:0] rdusedw0,
  input  logic [ADDR_W-1:0] rdusedw1,
  input  logic              rdempty0,
  input  logic              rdempty1,
  input  logic [DATA_W-1:0] q0,
  input  logic [DATA_W-1:0] q1,
  output logic              rdreq0,
  output logic              rdreq1,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ch,
  output logic              busy,
  output logic              underrun_err
);

  localparam logic [ADDR_W-1:0] LEN     = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ch_q, ch_d;
  logic              rd_prev_q;
  logic [7:0]        seq0_q, seq0_d, seq1_q, seq1_d;
  logic              rdreq0_d, rdreq1_d, busy_d, underrun_d;
  logic              out_valid_d, out_sop_d, out_eop_d;
  logic [DATA_W-1:0] out_data_d;
  logic [1:0]        elig;
  logic              take, gnt_valid, gnt_ch;

  assign elig[0] = (rdusedw0 >= LEN) && !rdempty0;
  assign elig[1] = (rdusedw1 >= LEN) && !rdempty1;
  assign take    = (state_q == ST_IDLE) && en && tx_ready;
  assign out_ch  = ch_q;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (elig),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt_ch    (gnt_ch)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    seq0_d      = seq0_q;
    seq1_d      = seq1_q;
    rdreq0_d    = 1'b0;
    rdreq1_d    = 1'b0;
    // FIFO data is valid the cycle after its rdreq, so data beats follow rd_prev_q.
    out_valid_d = rd_prev_q;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_data_d  = rd_prev_q ? (ch_q ? q1 : q0) : '0;
    underrun_d  = underrun_err | (rdreq0 & rdempty0) | (rdreq1 & rdempty1);

    case (state_q)
      ST_IDLE: begin
        if (take && gnt_valid) begin
          state_d  = ST_READ;
          ch_d     = gnt_ch;
          cnt_d    = LAST_RD;
          rdreq0_d = ~gnt_ch;
          rdreq1_d = gnt_ch;
        end
      end
      ST_READ: begin
        rdreq0_d = ~ch_q;
        rdreq1_d = ch_q;
        if (cnt_q == LAST_RD) begin
          out_valid_d = 1'b1;
          out_sop_d   = 1'b1;
          out_data_d  = '0;
          out_data_d[HDR_W-1:0] = make_header(ch_q, ch_q ? seq1_q : seq0_q);
          if (ch_q) seq1_d = seq1_q + 8'd1;
          else      seq0_d = seq0_q + 8'd1;
        end
        if (cnt_q == '0) begin
          state_d  = ST_DRAIN;
          cnt_d    = ADDR_W'(1);
          rdreq0_d = 1'b0;
          rdreq1_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        out_eop_d = rd_prev_q;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ch_q         <= 1'b0;
      rd_prev_q    <= 1'b0;
      seq0_q       <= '0;
      seq1_q       <= '0;
      rdreq0       <= 1'b0;
      rdreq1       <= 1'b0;
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      rd_prev_q    <= rdreq0 | rdreq1;
      seq0_q       <= seq0_d;
      seq1_q       <= seq1_d;
      rdreq0       <= rdreq0_d;
      rdreq1       <= rdreq1_d;
      out_valid    <= out_valid_d;
      out_sop      <= out_sop_d;
      out_eop      <= out_eop_d;
      out_data     <= out_data_d;
      busy         <= busy_d;
      underrun_err <= underrun_d;
    end
  end

endmodule

// File: tb/tb_dual_cam_burst_arbiter.sv
// Self-checking bench for dual_cam_burst_arbiter with BURST_LEN=4: directed
// scenarios plus randomized bursts against a burst-level reference model.
module tb_dual_cam_burst_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int BL     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              tx_ready = 1'b0;
  logic [ADDR_W-1:0] rdusedw0 = '0;
  logic [ADDR_W-1:0] rdusedw1 = '0;
  logic              rdempty0 = 1'b1;
  logic              rdempty1 = 1'b1;
  logic [DATA_W-1:0] q0 = '0;
  logic [DATA_W-1:0] q1 = '0;
  logic              rdreq0, rdreq1, out_valid, out_sop, out_eop, out_ch, busy, underrun_err;
  logic [DATA_W-1:0] out_data;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0]        m_seq [2];
  logic              m_last;
  logic              m_under;
  logic [DATA_W-1:0] fifo_words [$];
  logic [DATA_W-1:0] fw0, fw1;

  dual_cam_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tx_ready(tx_ready),
    .rdusedw0(rdusedw0), .rdusedw1(rdusedw1), .rdempty0(rdempty0), .rdempty1(rdempty1),
    .q0(q0), .q1(q1), .rdreq0(rdreq0), .rdreq1(rdreq1),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_ch(out_ch), .busy(busy), .underrun_err(underrun_err)
  );

  always #5 clk = ~clk;

  // Camera FIFO models: each read produces a fresh random word one cycle later.
  always @(posedge clk) begin
    if (rdreq0) begin
      fw0 = DATA_W'($urandom);
      q0 <= fw0;
      fifo_words.push_back(fw0);
    end
    if (rdreq1) begin
      fw1 = DATA_W'($urandom);
      q1 <= fw1;
      fifo_words.push_back(fw1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rr_pick(input bit e0, input bit e1, input logic last);
    if (e0 && e1) return ~last;
    return e1;
  endfunction

  task automatic pick_inputs(input bit e, output logic [ADDR_W-1:0] rdu, output logic emp);
    if (e) begin
      rdu = ADDR_W'($urandom_range(2**ADDR_W - 1, BL));
      emp = 1'b0;
    end else if ($urandom_range(1, 0) == 1) begin
      rdu = ADDR_W'($urandom_range(BL - 1, 0));
      emp = 1'($urandom_range(1, 0));
    end else begin
      rdu = ADDR_W'($urandom_range(2**ADDR_W - 1, BL));
      emp = 1'b1;
    end
  endtask

  task automatic make_ineligible();
    rdusedw0 = ADDR_W'($urandom_range(BL - 1, 0));
    rdusedw1 = ADDR_W'($urandom_range(BL - 1, 0));
    rdempty0 = 1'b0;
    rdempty1 = 1'b0;
  endtask

  task automatic apply_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rdreq",     32'({rdreq1, rdreq0}), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sop",   32'(out_sop), 32'd0);
    chk("rst_out_eop",   32'(out_eop), 32'd0);
    chk("rst_out_data",  32'(out_data), 32'd0);
    chk("rst_out_ch",    32'(out_ch), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_underrun",  32'(underrun_err), 32'd0);
    m_seq[0] = 8'd0;
    m_seq[1] = 8'd0;
    m_last   = 1'b1;
    m_under  = 1'b0;
    fifo_words.delete();
    make_ineligible();
    #2 rst_n = 1'b1;
  endtask

  // Starts right after a negedge; the grant cycle is the one in which tx_ready is first high.
  task automatic do_burst(input bit e0, input bit e1, input int pre_wait,
                          input bit disturb, input bit force_empty, input int abort_k);
    logic              ch;
    logic [15:0]       hdr;
    logic [DATA_W-1:0] wexp;
    logic [ADDR_W-1:0] rdu;
    logic              emp;
    ch  = rr_pick(e0, e1, m_last);
    hdr = {4'hA, 3'b000, ch, m_seq[ch]};
    pick_inputs(e0, rdu, emp); rdusedw0 = rdu; rdempty0 = emp;
    pick_inputs(e1, rdu, emp); rdusedw1 = rdu; rdempty1 = emp;
    en       = 1'b1;
    tx_ready = (pre_wait == 0);
    for (int i = 0; i < pre_wait; i++) begin
      @(negedge clk);
      chk("wait_rdreq", 32'({rdreq1, rdreq0}), 32'd0);
      chk("wait_busy",  32'(busy), 32'd0);
      if (i == pre_wait - 1) tx_ready = 1'b1;
    end
    m_seq[ch] = m_seq[ch] + 8'd1;
    m_last    = ch;
    for (int k = 1; k <= BL + 3; k++) begin
      @(negedge clk);
      chk("rdreq_gnt",   32'(ch ? rdreq1 : rdreq0), 32'(k <= BL));
      chk("rdreq_other", 32'(ch ? rdreq0 : rdreq1), 32'd0);
      chk("busy",        32'(busy), 32'(k <= BL + 2));
      chk("out_valid",   32'(out_valid), 32'(k >= 2 && k <= BL + 2));
      chk("out_sop",     32'(out_sop), 32'(k == 2));
      chk("out_eop",     32'(out_eop), 32'(k == BL + 2));
      if (k == 2) begin
        chk("header", 32'(out_data), 32'(hdr));
      end else if (k >= 3 && k <= BL + 2) begin
        wexp = (fifo_words.size() > 0) ? fifo_words.pop_front() : 'x;
        chk("data", 32'(out_data), 32'(wexp));
      end
      if (k >= 2 && k <= BL + 2) chk("out_ch", 32'(out_ch), 32'(ch));
      if (force_empty && k == 3) m_under = 1'b1;
      chk("underrun", 32'(underrun_err), 32'(m_under));
      if (k == abort_k) return;
      if (k <= BL) begin
        if (disturb) begin
          en       = 1'($urandom_range(1, 0));
          tx_ready = 1'($urandom_range(1, 0));
          rdusedw0 = ADDR_W'($urandom);
          rdusedw1 = ADDR_W'($urandom);
          if (ch) rdempty0 = 1'($urandom_range(1, 0));
          else    rdempty1 = 1'($urandom_range(1, 0));
        end
        if (ch) rdempty1 = force_empty && (k == 2);
        else    rdempty0 = force_empty && (k == 2);
      end else begin
        make_ineligible();
        if (disturb) en = 1'($urandom_range(1, 0));
      end
    end
  endtask

  initial begin
    int r;
    m_seq[0] = 8'd0;
    m_seq[1] = 8'd0;
    m_last   = 1'b1;
    m_under  = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_rdreq",     32'({rdreq1, rdreq0}), 32'd0);
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_busy",      32'(busy), 32'd0);
    chk("init_underrun",  32'(underrun_err), 32'd0);
    chk("init_out_data",  32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single channel-0 burst
    do_burst(1, 0, 0, 0, 0, 0);

    // alternation under constant contention from a fresh reset
    apply_reset();
    @(negedge clk);
    repeat (4) do_burst(1, 1, 0, 0, 0, 0);

    // channel 1 held off by tx_ready for 10 cycles
    do_burst(0, 1, 10, 0, 0, 0);

    // underrun on channel 0; flag must stay set afterwards
    do_burst(1, 0, 0, 0, 1, 0);
    do_burst(1, 1, 0, 1, 0, 0);

    // randomized contention with en/tx_ready/rdusedw disturbance mid-burst
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(2, 0));
      do_burst(r != 1, r != 0, int'($urandom_range(3, 0)), 1, 0, 0);
    end

    // 300 channel-0 bursts wrap its sequence count; channel 1 unaffected
    for (int i = 0; i < 300; i++) do_burst(1, 0, 0, 1'($urandom_range(1, 0)), 0, 0);
    do_burst(0, 1, 0, 0, 0, 0);

    // reset after the second data beat abandons the burst
    do_burst(1, 1, 0, 0, 0, 4);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_rdreq", 32'({rdreq1, rdreq0}), 32'd0);
    end
    do_burst(1, 1, 0, 0, 0, 0);
    do_burst(1, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
